// File: rtl/ce_tx_pkg.sv
// Shared types and helpers for the CE/D serial transmitter.
package ce_tx_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  // Counter width for a range of n values, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ce_strobe_gen.sv
// Bit-period prescaler: registered tick while count sits at DIV-1.
module ce_strobe_gen
  import ce_tx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic CK,
  input  logic RST_N,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick,
  output logic o_tick_nxt
);

  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // o_tick_nxt lets the parent predict the strobe one cycle ahead (DONE).
  always_comb begin
    w_cnt_nxt  = r_cnt;
    o_tick_nxt = 1'b0;
    if (i_clear) begin
      w_cnt_nxt  = '0;
      o_tick_nxt = (LAST == '0);
    end else if (i_run) begin
      w_cnt_nxt  = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      o_tick_nxt = (w_cnt_nxt == LAST);
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt  <= '0;
      o_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      o_tick <= o_tick_nxt;
    end
  end

endmodule

// File: rtl/ce_serial_tx.sv
// Parallel-to-serial transmitter driving a CE-qualified capture interface.
module ce_serial_tx
  import ce_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIV        = 4,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic             CE,
  output logic             D,
  output logic             BUSY,
  output logic             DONE
);

  localparam int BW = cnt_w(WIDTH + 1);
  localparam int GW = cnt_w(GAP_CYCLES);
  localparam bit MSBF    = (MSB_FIRST != 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sh, w_sh_nxt;
  logic [BW-1:0]    r_bitcnt, w_bitcnt_nxt;
  logic [GW-1:0]    r_gapcnt, w_gapcnt_nxt;
  logic             r_ready, r_d, r_busy, r_done;
  logic             w_ready_nxt, w_d_nxt, w_busy_nxt, w_done_nxt;
  logic             w_accept, w_last, w_run, w_tick_nxt, w_ce;

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSBF ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift(input logic [WIDTH-1:0] v);
    return MSBF ? (v << 1) : (v >> 1);
  endfunction

  assign w_accept = (r_state == IDLE) && r_ready && VALID_IN;
  assign w_last   = (r_state == SHIFT) && w_ce && (r_bitcnt == LAST_BIT);
  assign w_run    = (r_state == SHIFT) && !w_last;

  ce_strobe_gen #(.DIV(DIV)) u_strobe (
    .CK        (CK),
    .RST_N     (RST_N),
    .i_clear   (w_accept),
    .i_run     (w_run),
    .o_tick    (w_ce),
    .o_tick_nxt(w_tick_nxt)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_sh_nxt     = r_sh;
    w_bitcnt_nxt = r_bitcnt;
    w_gapcnt_nxt = r_gapcnt;
    w_ready_nxt  = r_ready;
    w_busy_nxt   = r_busy;
    w_d_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        if (w_accept) begin
          w_state_nxt  = SHIFT;
          w_sh_nxt     = DATA_IN;
          w_bitcnt_nxt = '0;
          w_ready_nxt  = 1'b0;
          w_busy_nxt   = 1'b1;
          w_d_nxt      = head(DATA_IN);
        end
      end
      SHIFT: begin
        w_d_nxt = r_d;
        if (w_last) begin
          w_d_nxt = 1'b0;
          if (HAS_GAP) begin
            w_state_nxt  = GAP;
            w_gapcnt_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
          end
        end else if (w_ce) begin
          // Next bit lands on D the cycle after the strobe.
          w_sh_nxt     = shift(r_sh);
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          w_d_nxt      = head(shift(r_sh));
        end
      end
      GAP: begin
        if (r_gapcnt == LAST_GAP) begin
          w_state_nxt = IDLE;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_gapcnt_nxt = r_gapcnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_done_nxt = (w_state_nxt == SHIFT) && w_tick_nxt && (w_bitcnt_nxt == LAST_BIT);
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= IDLE;
      r_sh     <= '0;
      r_bitcnt <= '0;
      r_gapcnt <= '0;
      r_ready  <= 1'b0;
      r_d      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sh     <= w_sh_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_gapcnt <= w_gapcnt_nxt;
      r_ready  <= w_ready_nxt;
      r_d      <= w_d_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign READY_OUT = r_ready;
  assign CE        = w_ce;
  assign D         = r_d;
  assign BUSY      = r_busy;
  assign DONE      = r_done;

endmodule

// File: tb/tb_ce_serial_tx.sv
// Self-checking bench for ce_serial_tx against a per-cycle timing model.
module tb_ce_serial_tx;

  logic CK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CK = ~CK;

  int n_checks = 0;
  int n_errors = 0;

  // a: defaults, b: LSB first / DIV=1 / no gap, c: WIDTH=1 / DIV=3 / GAP=2
  logic [7:0] a_data = '0, b_data = '0;
  logic [0:0] c_data = '0;
  logic a_valid = 0, b_valid = 0, c_valid = 0;
  logic a_ready, a_ce, a_d, a_busy, a_done;
  logic b_ready, b_ce, b_d, b_busy, b_done;
  logic c_ready, c_ce, c_d, c_busy, c_done;
  logic [4:0] a_obs, b_obs, c_obs;
  assign a_obs = {a_ready, a_busy, a_ce, a_d, a_done};
  assign b_obs = {b_ready, b_busy, b_ce, b_d, b_done};
  assign c_obs = {c_ready, c_busy, c_ce, c_d, c_done};

  ce_serial_tx u_a (
    .CK(CK), .RST_N(RST_N), .DATA_IN(a_data), .VALID_IN(a_valid), .READY_OUT(a_ready),
    .CE(a_ce), .D(a_d), .BUSY(a_busy), .DONE(a_done));

  ce_serial_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(0), .GAP_CYCLES(0)) u_b (
    .CK(CK), .RST_N(RST_N), .DATA_IN(b_data), .VALID_IN(b_valid), .READY_OUT(b_ready),
    .CE(b_ce), .D(b_d), .BUSY(b_busy), .DONE(b_done));

  ce_serial_tx #(.WIDTH(1), .DIV(3), .MSB_FIRST(1), .GAP_CYCLES(2)) u_c (
    .CK(CK), .RST_N(RST_N), .DATA_IN(c_data), .VALID_IN(c_valid), .READY_OUT(c_ready),
    .CE(c_ce), .D(c_d), .BUSY(c_busy), .DONE(c_done));

  // Expected {READY,BUSY,CE,D,DONE} in cycle j after the accept edge.
  function automatic logic [4:0] model(int w, int div, int msb, int gap, logic [7:0] word, int j);
    int n;
    logic [4:0] r;
    if (j <= w * div) begin
      n = (j - 1) / div;
      r = {1'b0, 1'b1, (j % div) == 0, word[(msb != 0) ? (w - 1 - n) : n], j == w * div};
    end else if (j <= w * div + gap) begin
      r = 5'b01000;
    end else begin
      r = 5'b10000;
    end
    return r;
  endfunction

  // Returns at a negedge where the selected READY is high.
  task automatic wait_ready(input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CK);
      if ((sel == 0 && a_ready) || (sel == 1 && b_ready) || (sel == 2 && c_ready)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (2) @(negedge CK);
    n_checks++;
    if ({a_obs, b_obs, c_obs} !== 15'b0) begin
      n_errors++;
      $display("FAIL reset_state got=%b/%b/%b exp=all zero", a_obs, b_obs, c_obs);
    end
    RST_N = 1'b1;
    @(negedge CK);
    n_checks++;
    if ({a_obs, b_obs, c_obs} !== {5'b10000, 5'b10000, 5'b10000}) begin
      n_errors++;
      $display("FAIL ready_after_reset got=%b/%b/%b exp=10000 each", a_obs, b_obs, c_obs);
    end
  endtask

  task automatic test_basic;
    bit ok;
    logic [4:0] e;
    wait_ready(0, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL basic_ready got=timeout exp=ready"); return; end
    a_data = 8'hA5; a_valid = 1'b1;
    @(posedge CK); #1 a_valid = 1'b0;
    for (int j = 1; j <= 35; j++) begin
      @(negedge CK);
      e = model(8, 4, 1, 1, 8'hA5, j);
      n_checks++;
      if (a_obs !== e) begin
        n_errors++;
        $display("FAIL basic j=%0d got=%b exp=%b", j, a_obs, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int ce_cnt, done_cnt;
    logic [4:0] e;
    ce_cnt = 0; done_cnt = 0;
    wait_ready(1, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL b2b_ready got=timeout exp=ready"); return; end
    b_data = 8'h01; b_valid = 1'b1;
    @(posedge CK); #1 b_data = 8'hFF;
    for (int j = 1; j <= 18; j++) begin
      @(negedge CK);
      e = (j <= 9) ? model(8, 1, 0, 0, 8'h01, j) : model(8, 1, 0, 0, 8'hFF, j - 9);
      ce_cnt += int'(b_ce);
      done_cnt += int'(b_done);
      n_checks++;
      if (b_obs !== e) begin
        n_errors++;
        $display("FAIL b2b j=%0d got=%b exp=%b", j, b_obs, e);
      end
      if (j == 10) b_valid = 1'b0;
    end
    n_checks++;
    if (ce_cnt != 16 || done_cnt != 2) begin
      n_errors++;
      $display("FAIL b2b_counts got ce=%0d done=%0d exp ce=16 done=2", ce_cnt, done_cnt);
    end
  endtask

  task automatic test_ignore_busy;
    bit ok;
    logic [7:0] x, y;
    logic [4:0] e;
    x = 8'($urandom); y = 8'($urandom);
    wait_ready(0, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL busy_ready got=timeout exp=ready"); return; end
    a_data = x; a_valid = 1'b1;
    @(posedge CK); #1;
    for (int j = 1; j <= 69; j++) begin
      @(negedge CK);
      e = (j <= 34) ? model(8, 4, 1, 1, x, j) : model(8, 4, 1, 1, y, j - 34);
      n_checks++;
      if (a_obs !== e) begin
        n_errors++;
        $display("FAIL ignore_busy j=%0d got=%b exp=%b", j, a_obs, e);
      end
      if (j < 33) begin
        a_valid = 1'($urandom);
        a_data  = 8'($urandom);
      end else if (j == 33) begin
        a_valid = 1'b1;
        a_data  = y;
      end else if (j == 35) begin
        a_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int ce_seen;
    logic [7:0] w;
    logic [4:0] e;
    ce_seen = 0;
    wait_ready(0, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL rstmid_ready got=timeout exp=ready"); return; end
    a_data = 8'($urandom); a_valid = 1'b1;
    @(posedge CK); #1 a_valid = 1'b0;
    for (int j = 0; j < 40 && ce_seen < 3; j++) begin
      @(negedge CK);
      ce_seen += int'(a_ce);
    end
    n_checks++;
    if (ce_seen != 3) begin
      n_errors++;
      $display("FAIL rstmid_ce got=%0d exp=3", ce_seen);
    end
    @(posedge CK); #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if (a_obs !== 5'b0) begin
      n_errors++;
      $display("FAIL rstmid_async got=%b exp=00000", a_obs);
    end
    repeat (2) @(negedge CK);
    n_checks++;
    if (a_obs !== 5'b0) begin
      n_errors++;
      $display("FAIL rstmid_hold got=%b exp=00000", a_obs);
    end
    RST_N = 1'b1;
    w = 8'($urandom);
    wait_ready(0, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL rstmid_ready2 got=timeout exp=ready"); return; end
    a_data = w; a_valid = 1'b1;
    @(posedge CK); #1 a_valid = 1'b0;
    for (int j = 1; j <= 35; j++) begin
      @(negedge CK);
      e = model(8, 4, 1, 1, w, j);
      n_checks++;
      if (a_obs !== e) begin
        n_errors++;
        $display("FAIL rstmid_next j=%0d got=%b exp=%b", j, a_obs, e);
      end
    end
  endtask

  task automatic test_width1;
    bit ok;
    logic [4:0] e;
    for (int k = 0; k < 2; k++) begin
      wait_ready(2, ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL w1_ready got=timeout exp=ready"); return; end
      c_data = (k == 0) ? 1'b1 : 1'b0; c_valid = 1'b1;
      @(posedge CK); #1 c_valid = 1'b0;
      for (int j = 1; j <= 6; j++) begin
        @(negedge CK);
        e = model(1, 3, 1, 2, {7'b0, c_data}, j);
        n_checks++;
        if (c_obs !== e) begin
          n_errors++;
          $display("FAIL width1 k=%0d j=%0d got=%b exp=%b", k, j, c_obs, e);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] expq[$];
    bit drv_done, ok;
    int ce_cnt, done_cnt, nb;
    logic [7:0] sh, e;
    drv_done = 0; ce_cnt = 0; done_cnt = 0; nb = 0; sh = '0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 6)) @(negedge CK);
          wait_ready(0, ok);
          if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL rand_ready word=%0d got=timeout exp=ready", i);
            break;
          end
          a_data = 8'($urandom); a_valid = 1'b1;
          expq.push_back(a_data);
          @(posedge CK); #1 a_valid = 1'b0;
        end
        drv_done = 1;
      end
      begin
        for (int c = 0; c < 20000; c++) begin
          @(negedge CK);
          done_cnt += int'(a_done);
          if (a_ce) begin
            ce_cnt++;
            sh = {sh[6:0], a_d};
            nb++;
            if (nb == 8) begin
              nb = 0;
              n_checks++;
              if (expq.size() == 0) begin
                n_errors++;
                $display("FAIL rand_word got=%h exp=none queued", sh);
              end else begin
                e = expq.pop_front();
                if (sh !== e) begin
                  n_errors++;
                  $display("FAIL rand_word got=%h exp=%h", sh, e);
                end
              end
            end
          end
          if (drv_done && !a_busy) break;
        end
      end
    join
    n_checks++;
    if (ce_cnt != 800 || done_cnt != 100 || expq.size() != 0) begin
      n_errors++;
      $display("FAIL rand_counts got ce=%0d done=%0d left=%0d exp ce=800 done=100 left=0",
               ce_cnt, done_cnt, expq.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_ignore_busy;
    test_reset_mid;
    test_width1;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
